// File: rtl/console_key_pulser_pkg.sv
// Shared definitions for the console key pulser: clock tick, time conversion, FSM states.
package console_key_pulser_pkg;

  localparam int unsigned TICK_NS = 20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    RPT_WAIT = 2'd2,
    RPT_PEND = 2'd3
  } state_t;

  // Rounds up so a requested delay is never shortened.
  function automatic int unsigned ns_to_cyc(input int unsigned ns);
    return (ns + TICK_NS - 1) / TICK_NS;
  endfunction

endpackage

// File: rtl/console_key_pulser_sync2.sv
// Two-flop synchronizer for one asynchronous level input.
module console_key_pulser_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/console_key_pulser.sv
// Debounces one console key into a clean level plus press/auto-repeat trigger pulses.
// Handshake: key_p is a one-cycle strobe with no back-pressure; inhibit only defers repeats.
module console_key_pulser
  import console_key_pulser_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = ns_to_cyc(5_000_000),
  parameter int          RW           = 26
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          key_in,
  input  logic          repeat_en,
  input  logic [RW-1:0] repeat_cyc,
  input  logic          inhibit,
  output logic          key_l,
  output logic          key_p,
  output logic          pending,
  output state_t        dbg_state
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          key_s;
  logic          rpt_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_l_q, key_l_d;
  logic          key_p_q, key_p_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [RW-1:0] rpt_load;
  state_t        state_q, state_d;
  logic          press;
  logic          release_ev;

  console_key_pulser_sync2 u_sync_key (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (key_in),
    .q       (key_s)
  );

  console_key_pulser_sync2 u_sync_rpt (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (repeat_en),
    .q       (rpt_s)
  );

  // A level is accepted after DEBOUNCE_CYC counted mismatches plus the accepting edge.
  always_comb begin
    cnt_d   = '0;
    key_l_d = key_l_q;
    if (key_s != key_l_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC)) begin
        key_l_d = key_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press      = key_l_d & ~key_l_q;
  assign release_ev = ~key_l_d & key_l_q;
  // Interval of 0 behaves as 1, so the reload value saturates at zero.
  assign rpt_load   = (repeat_cyc == '0) ? '0 : repeat_cyc - RW'(1);

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    key_p_d = 1'b0;
    if (release_ev) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            key_p_d = 1'b1;
            state_d = HELD;
          end
        end
        HELD: begin
          if (rpt_s) begin
            rcnt_d  = rpt_load;
            state_d = RPT_WAIT;
          end
        end
        RPT_WAIT: begin
          if (!rpt_s) begin
            state_d = HELD;
            rcnt_d  = '0;
          end else if (rcnt_q == '0) begin
            if (!inhibit) begin
              key_p_d = 1'b1;
              rcnt_d  = rpt_load;
            end else begin
              state_d = RPT_PEND;
            end
          end else begin
            rcnt_d = rcnt_q - RW'(1);
          end
        end
        RPT_PEND: begin
          if (!rpt_s) begin
            state_d = HELD;
            rcnt_d  = '0;
          end else if (!inhibit) begin
            key_p_d = 1'b1;
            rcnt_d  = rpt_load;
            state_d = RPT_WAIT;
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      key_l_q <= 1'b0;
      key_p_q <= 1'b0;
      rcnt_q  <= '0;
      state_q <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      key_l_q <= key_l_d;
      key_p_q <= key_p_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
    end
  end

  assign key_l     = key_l_q;
  assign key_p     = key_p_q;
  assign pending   = (state_q == RPT_PEND);
  assign dbg_state = state_q;

endmodule
